// File: rtl/bus_drive_decoder_if.sv
// Request/drive bundle between a bus requester and the bus drive decoder.
// The requester drives the request fields; the decoder returns the drive state.
interface bus_drive_decoder_if #(
  parameter int HOLD_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_sel;
  logic [HOLD_W-1:0] req_hold;
  logic              abort;
  logic [31:0]       drive_en;
  logic [4:0]        drive_idx;
  logic              busy;
  logic              done;

  modport master (
    output req_valid, req_sel, req_hold, abort,
    input  req_ready, drive_en, drive_idx, busy, done
  );

  modport slave (
    input  req_valid, req_sel, req_hold, abort,
    output req_ready, drive_en, drive_idx, busy, done
  );
endinterface

// File: rtl/bus_drive_decoder.sv
// Registered 5-to-32 one-hot bus drive enable with programmable hold length
// and a mandatory one-cycle dead gap between drives.
module bus_drive_decoder #(
  parameter int HOLD_W = 4
) (
  input  logic               clk,
  input  logic               clr_n,
  bus_drive_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] cnt, cnt_nxt;
  logic [31:0]       drive_en_p1, drive_en_nxt;
  logic [4:0]        drive_idx_p1, drive_idx_nxt;
  logic              done_p1, done_nxt;
  logic              busy_p1, busy_nxt;

  // A hold of zero still drives for one cycle, so it loads the same count as one.
  function automatic logic [HOLD_W-1:0] load_count(input logic [HOLD_W-1:0] hold);
    return (hold == '0) ? '0 : hold - HOLD_W'(1);
  endfunction

  function automatic logic [31:0] one_hot(input logic [4:0] sel);
    return 32'd1 << sel;
  endfunction

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    drive_en_nxt  = drive_en_p1;
    drive_idx_nxt = drive_idx_p1;
    done_nxt      = 1'b0;
    busy_nxt      = busy_p1;

    case (state)
      IDLE: begin
        drive_en_nxt = '0;
        busy_nxt     = 1'b0;
        if (bus.req_valid) begin
          drive_idx_nxt = bus.req_sel;
          drive_en_nxt  = one_hot(bus.req_sel);
          cnt_nxt       = load_count(bus.req_hold);
          busy_nxt      = 1'b1;
          state_nxt     = DRIVE;
        end
      end
      DRIVE: begin
        busy_nxt = 1'b1;
        if ((cnt == '0) || bus.abort) begin
          drive_en_nxt = '0;
          done_nxt     = 1'b1;
          state_nxt    = GAP;
        end else begin
          cnt_nxt = cnt - HOLD_W'(1);
        end
      end
      GAP: begin
        drive_en_nxt = '0;
        busy_nxt     = 1'b0;
        state_nxt    = IDLE;
      end
      default: begin
        drive_en_nxt = '0;
        busy_nxt     = 1'b0;
        state_nxt    = IDLE;
      end
    endcase
  end

  // Output register stage: everything the bus sees comes straight from flops.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state        <= IDLE;
      cnt          <= '0;
      drive_en_p1  <= '0;
      drive_idx_p1 <= '0;
      done_p1      <= 1'b0;
      busy_p1      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      drive_en_p1  <= drive_en_nxt;
      drive_idx_p1 <= drive_idx_nxt;
      done_p1      <= done_nxt;
      busy_p1      <= busy_nxt;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.drive_en  = drive_en_p1;
  assign bus.drive_idx = drive_idx_p1;
  assign bus.done      = done_p1;
  assign bus.busy      = busy_p1;

endmodule

// File: doc/bus_drive_decoder.md
# bus_drive_decoder

Registered 5-to-32 decoder that turns a binary register index into a one-hot bus drive enable for the shared 32-source datapath bus. It sits on the control side of the bus, ahead of the one-hot-to-binary encoder that generates the bus mux select. Each request holds the enable for a programmed number of cycles, then inserts a one-cycle dead gap so no two sources ever overlap on the bus.

## Interface
- HOLD_W, 4, width of the hold-count field; maximum drive length is 2^HOLD_W-1 cycles.

- clk  input  1  rising-edge clock
- clr_n  input  1  synchronous reset, active-low; sampled on rising clk
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_sel  input  5  binary index of the source to drive onto the bus
- req_hold  input  HOLD_W  drive length in cycles; 0 is treated as 1
- abort  input  1  terminate the current drive early
- drive_en  output  32  one-hot bus drive enable, registered
- drive_idx  output  5  index currently or last driven, registered
- busy  output  1  high in DRIVE and GAP
- done  output  1  one-cycle pulse in the GAP cycle

## Operation
- Reset (clr_n low at a clk edge): state IDLE, drive_en=0, drive_idx=0, done=0, busy=0, internal counter=0. req_ready=1 from the first cycle after reset.
- The state machine has three states: IDLE, DRIVE and GAP.
- IDLE:
  - req_ready=1, drive_en=0.
  - On req_valid&req_ready at an edge: latch req_sel into drive_idx, set drive_en=1<<req_sel, load counter=max(req_hold,1)-1, go to DRIVE.
  - abort is ignored in IDLE.
- DRIVE:
  - req_ready=0, busy=1, drive_en holds its one-hot value.
  - If counter==0 or abort=1 at an edge: drive_en becomes 0, done becomes 1, go to GAP.
  - Otherwise decrement the counter.
- GAP:
  - Lasts exactly one cycle with drive_en=0, done=1, busy=1, req_ready=0.
  - Next edge: done becomes 0, busy becomes 0, go to IDLE.
- Requests presented while req_ready=0 are not consumed. The requester must hold req_valid and its fields stable until accepted.
- drive_idx keeps the last driven index through GAP and IDLE, until the next accept or reset.
- Invariants:
  - popcount(drive_en) ≤ 1 at all times.
  - drive_en is 0 whenever state≠DRIVE.
  - drive_en == 1<<drive_idx whenever state==DRIVE.
  - done implies drive_en==0.
- All outputs except req_ready are flops. req_ready is decoded from the state register only, with no input-to-output combinational path.

## Timing
- Accept at edge k: drive_en is valid in cycles k+1 … k+N, where N=max(req_hold,1).
- GAP and done occupy cycle k+N+1. req_ready returns to 1 in cycle k+N+2.
- Minimum request period is N+2 cycles. With req_hold ≤ 1, accepts can occur every 3 cycles.
- Abort sampled high at edge m while in DRIVE: drive_en=0 and done=1 from cycle m+1, giving the same GAP/IDLE sequence. If abort and counter==0 occur on the same edge, behaviour is identical to a normal end.
- Reset mid-DRIVE or mid-GAP: all outputs take their reset values at that edge, no done pulse is produced, and any in-flight request is lost.
- Reset has priority over abort and req_valid on the same edge.
- req_hold of all ones (15 with default HOLD_W) gives 15 drive cycles. The counter never wraps.

## Test plan
- Reset, then req_sel=5, req_hold=3 accepted at edge 0 -> drive_en=32'h00000020 in cycles 1-3, drive_idx=5, done=1 and drive_en=0 in cycle 4, req_ready=1 in cycle 5.
- req_hold=0 and req_sel=31 -> drive_en=32'h80000000 for exactly 1 cycle, then GAP. req_sel=0, req_hold=15 -> drive_en=32'h00000001 for 15 cycles.
- req_valid held high continuously with sel 2, then 3 -> the two drive windows are separated by exactly one cycle of drive_en=0. Popcount never exceeds 1, and the second request is not consumed early.
- Abort asserted in the 2nd cycle of a req_hold=8 drive -> drive_en=0 and done=1 in the next cycle, then IDLE. Abort asserted in IDLE with req_valid=1 -> the request is accepted normally.
- clr_n low during cycle 2 of a req_hold=5 drive -> next cycle all outputs are 0, req_ready=1, and no done pulse appears.
- Randomised sweep of all 32 indices against a reference model -> drive_en==1<<drive_idx throughout DRIVE, and every accept is followed by exactly one done pulse.
